isqrt_pipe: RTL

//  Fully pipelined unsigned integer square root: y = floor(sqrt(x)).
//  - Responder side of the isqrt_x_vld/isqrt_x -> isqrt_y_vld/isqrt_y interface.
//  - Driven by the formula FSMs that issue one argument per cycle.
//  - Accepts a new argument every clock, no backpressure, fixed latency LAT.

---
 rtl/isqrt_pkg.sv | 42 ++++
 rtl/isqrt_stage.sv | 81 ++++++++
 rtl/isqrt_pipe.sv | 61 ++++++
 3 files changed

// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared types and helpers for the pipelined integer square root.
//
// Contents
//   MAX_N          widest supported result (argument width up to 2*MAX_N)
//   isqrt_stage_t  per-stage state {vld, rem, root, xres}, sized for MAX_N.
//                  Narrower builds zero-pad the unused upper bits.
//   isqrt_iter     one restoring root-digit iteration, returns {rem, root}
//   lat            register-stage count for a given WIDTH / ITER_PER_STAGE
package isqrt_pkg;

  localparam int MAX_N = 32;

  typedef struct packed {
    logic                 vld;
    logic [MAX_N+1:0]     rem;
    logic [MAX_N-1:0]     root;
    logic [2*MAX_N-1:0]   xres;
  } isqrt_stage_t;

  // One digit of the restoring square root. The caller guarantees that rem
  // fits in MAX_N bits before the shift, so dropping its top two bits is lossless.
  function automatic logic [2*MAX_N+1:0] isqrt_iter(
    input logic [MAX_N+1:0] rem,
    input logic [MAX_N-1:0] root,
    input logic [1:0]       xpair
  );
    logic [MAX_N+1:0] rem_s;
    logic [MAX_N+1:0] trial;
    rem_s = {rem[MAX_N-1:0], xpair};
    trial = {root, 2'b01};
    if (rem_s >= trial) begin
      return {rem_s - trial, root[MAX_N-2:0], 1'b1};
    end else begin
      return {rem_s, root[MAX_N-2:0], 1'b0};
    end
  endfunction

  function automatic int lat(input int width, input int iter_per_stage);
    return (width / 2) / iter_per_stage;
  endfunction

endpackage

// File: rtl/isqrt_stage.sv
// isqrt_stage: one register stage of the square-root pipeline.
//
// Applies ITER_PER_STAGE root-digit iterations combinationally to the incoming
// state, then registers the result. The valid bit always shifts and is cleared
// by rst; the data registers load only when the incoming valid is set, so
// bubbles leave them untouched.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (valid bit only)
//   in_s   in   state from the previous stage (or the argument port)
//   out_s  out  registered state, upper unused bits zero
module isqrt_stage
  import isqrt_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ITER_PER_STAGE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  isqrt_stage_t in_s,
  output isqrt_stage_t out_s
);

  localparam int N = WIDTH / 2;

  logic [MAX_N+1:0]   rem_c;
  logic [MAX_N-1:0]   root_c;
  logic [2*MAX_N-1:0] xres_c;
  logic [2*MAX_N+1:0] step;

  // The next argument bit pair always sits at the top of the live WIDTH-bit
  // residue; the residue shifts left after each pair is consumed.
  always_comb begin
    rem_c  = in_s.rem;
    root_c = in_s.root;
    xres_c = in_s.xres;
    step   = '0;
    for (int i = 0; i < ITER_PER_STAGE; i++) begin
      step   = isqrt_iter(rem_c, root_c, xres_c[WIDTH-1 -: 2]);
      rem_c  = step[2*MAX_N+1 -: MAX_N+2];
      root_c = step[MAX_N-1:0];
      xres_c = xres_c << 2;
    end
  end

  // ---- stage register boundary ----
  logic             vld_p0;
  logic [N+1:0]     rem_p0;
  logic [N-1:0]     root_p0;
  logic [WIDTH-1:0] xres_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= in_s.vld;
    end
  end

  always_ff @(posedge clk) begin
    if (in_s.vld) begin
      rem_p0  <= rem_c[N+1:0];
      root_p0 <= root_c[N-1:0];
      xres_p0 <= xres_c[WIDTH-1:0];
    end
  end

  always_comb begin
    out_s                 = '0;
    out_s.vld             = vld_p0;
    out_s.rem[N+1:0]      = rem_p0;
    out_s.root[N-1:0]     = root_p0;
    out_s.xres[WIDTH-1:0] = xres_p0;
  end

  // Bits above the live widths are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{rem_c, root_c, xres_c, step};

endmodule

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fully pipelined unsigned integer square root, y = floor(sqrt(x)).
//
// Accepts one argument per clock with no backpressure and returns the result
// a fixed LAT = (WIDTH/2)/ITER_PER_STAGE clocks later. The input valid pattern,
// including bubbles, is reproduced at the output delayed by LAT.
//
// Ports
//   clk    in   1          clock, rising edge
//   rst    in   1          synchronous active-high reset; drops in-flight results
//   x_vld  in   1          argument valid
//   x      in   WIDTH      unsigned argument
//   y_vld  out  1          result valid, one pulse per accepted argument
//   y      out  WIDTH/2    floor square root, meaningful when y_vld=1
module isqrt_pipe
  import isqrt_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ITER_PER_STAGE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_vld,
  input  logic [WIDTH-1:0]     x,
  output logic                 y_vld,
  output logic [WIDTH/2-1:0]   y
);

  localparam int N   = WIDTH / 2;
  localparam int LAT = lat(WIDTH, ITER_PER_STAGE);

  if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 2 * MAX_N) begin : g_bad_width
    $error("isqrt_pipe: WIDTH must be even, >= 4 and <= %0d", 2 * MAX_N);
  end
  if (ITER_PER_STAGE < 1 || (N % ITER_PER_STAGE) != 0) begin : g_bad_iter
    $error("isqrt_pipe: ITER_PER_STAGE must divide WIDTH/2");
  end

  isqrt_stage_t chain [LAT+1];

  assign chain[0] = '{vld: x_vld, rem: '0, root: '0, xres: (2*MAX_N)'(x)};

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    isqrt_stage #(
      .WIDTH         (WIDTH),
      .ITER_PER_STAGE(ITER_PER_STAGE)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .in_s (chain[k]),
      .out_s(chain[k+1])
    );
  end

  assign y_vld = chain[LAT].vld;
  assign y     = chain[LAT].root[N-1:0];

  // Final remainder and residue are not part of the result.
  logic unused_bits;
  assign unused_bits = ^{chain[LAT].rem, chain[LAT].root, chain[LAT].xres};

endmodule
